count_sequencer: RTL and testbench



---
 rtl/count_seq_pkg.sv | 15 +
 rtl/tick_gen.sv | 32 +++
 rtl/count_sequencer.sv | 107 ++++++++++
 tb/tb_count_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: command op-codes and FSM state encoding.
package count_seq_pkg;

  localparam logic [1:0] OP_STOP    = 2'b00;
  localparam logic [1:0] OP_RUN     = 2'b01;
  localparam logic [1:0] OP_PRESET  = 2'b10;
  localparam logic [1:0] OP_REVERSE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PRESET = 2'b10
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Programmable prescaler: one-cycle registered tick every div+1 cycles while run is high.
module tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] pre;

  // div is compared live, so lowering it below pre fires on the next edge
  always_ff @(posedge clk) begin
    if (reset) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (clr || !run) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (pre >= div) begin
      pre  <= '0;
      tick <= 1'b1;
    end else begin
      pre  <= pre + DIV_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven controller for a loadable up/down counter: prescaled run, preset,
// direction reversal and optional ping-pong between 0 and limit using the fed-back count.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [N-1:0]     cmd_data,
  input  logic [DIV_W-1:0] div,
  input  logic             bounce,
  input  logic [N-1:0]     limit,
  input  logic [N-1:0]     q_fb,
  output logic             enable,
  output logic             up,
  output logic             load,
  output logic [N-1:0]     load_val
);

  state_t state;
  state_t ret_state;

  logic accept;
  logic accept_stop;
  logic accept_run;
  logic accept_preset;
  logic accept_reverse;
  logic tick_run;
  logic tick_clr;
  logic tick;
  logic bounce_hit;

  assign accept         = cmd_valid && cmd_ready && !reset;
  assign accept_stop    = accept && (cmd_op == OP_STOP);
  assign accept_run     = accept && (cmd_op == OP_RUN);
  assign accept_preset  = accept && (cmd_op == OP_PRESET);
  assign accept_reverse = accept && (cmd_op == OP_REVERSE);

  // A tick falling due on the edge that leaves RUN is dropped, not delivered late
  assign tick_run = (state == ST_RUN) && !accept_stop && !accept_preset;
  assign tick_clr = accept_run || (state == ST_PRESET);

  tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .run  (tick_run),
    .clr  (tick_clr),
    .div  (div),
    .tick (tick)
  );

  // Both terms are flop outputs and never overlap: the prescaler is held off during PRESET
  assign enable = tick | load;

  // Either bound condition is a flip of the current direction
  assign bounce_hit = bounce && (limit != '0) && (state == ST_RUN) &&
                      (((q_fb == limit) && up) || ((q_fb == '0) && !up));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      up        <= 1'b1;
      load      <= 1'b0;
      load_val  <= '0;
      cmd_ready <= 1'b0;
    end else begin
      load      <= 1'b0;
      cmd_ready <= 1'b1;
      case (state)
        ST_IDLE, ST_RUN: begin
          if (accept) begin
            case (cmd_op)
              OP_STOP:    state <= ST_IDLE;
              OP_RUN:     state <= ST_RUN;
              OP_PRESET: begin
                load_val  <= cmd_data;
                ret_state <= state;
                state     <= ST_PRESET;
                load      <= 1'b1;
                cmd_ready <= 1'b0;
              end
              OP_REVERSE: state <= state;
            endcase
          end
        end
        ST_PRESET: state <= ret_state;
        default:   state <= ST_IDLE;
      endcase

      // An explicit REVERSE wins over a bound hit in the same cycle
      if (accept_reverse) begin
        up <= ~up;
      end else if (bounce_hit) begin
        up <= ~up;
      end
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a falling-edge counter model closing the q_fb loop.
module tb_count_sequencer;
  import count_seq_pkg::*;

  localparam int N     = 4;
  localparam int DIV_W = 8;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [N-1:0]     cmd_data;
  logic [DIV_W-1:0] div;
  logic             bounce;
  logic [N-1:0]     limit;
  logic [N-1:0]     q_fb;
  logic             enable;
  logic             up;
  logic             load;
  logic [N-1:0]     load_val;

  logic [N-1:0]     ctr;
  logic [N-1:0]     q_force;
  logic             use_model;
  logic [N-1:0]     bseq [12];

  int checks;
  int errors;

  count_sequencer #(
    .N    (N),
    .DIV_W(DIV_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .div      (div),
    .bounce   (bounce),
    .limit    (limit),
    .q_fb     (q_fb),
    .enable   (enable),
    .up       (up),
    .load     (load),
    .load_val (load_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counter: samples its controls on the falling edge
  always @(negedge clk) begin
    if (reset)       ctr <= '0;
    else if (load)   ctr <= load_val;
    else if (enable) ctr <= up ? ctr + 4'd1 : ctr - 4'd1;
  end

  assign q_fb = use_model ? ctr : q_force;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [N-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_STOP;
    cmd_data  = '0;
    div       = '0;
    bounce    = 1'b0;
    limit     = '0;
    q_force   = '0;
    use_model = 1'b1;
    bseq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2};

    step();
    step();
    chk("rst_enable", enable, 0);
    chk("rst_up", up, 1);
    chk("rst_load", load, 0);
    chk("rst_load_val", load_val, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    step();
    chk("ready_after_rst", cmd_ready, 1);

    // RUN with div=2: pulse on every third cycle, first one three cycles after acceptance
    div = 8'd2;
    drive_cmd(OP_RUN, '0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("div2_en_c%0d", i), enable, (i % 3 == 0) ? 1 : 0);
    end
    chk("div2_up", up, 1);
    drive_cmd(OP_STOP, '0);
    chk("stop_en0", enable, 0);
    step();
    chk("stop_en1", enable, 0);

    // PRESET 9 from IDLE
    drive_cmd(OP_PRESET, 4'd9);
    chk("pre9_load", load, 1);
    chk("pre9_enable", enable, 1);
    chk("pre9_load_val", load_val, 9);
    chk("pre9_ready", cmd_ready, 0);
    step();
    chk("pre9_load_off", load, 0);
    chk("pre9_enable_off", enable, 0);
    chk("pre9_ready_back", cmd_ready, 1);
    chk("pre9_ctr", ctr, 9);
    step();
    chk("pre9_idle_en", enable, 0);

    // Bounce between 0 and 5 with div=0
    drive_cmd(OP_PRESET, 4'd0);
    step();
    div    = 8'd0;
    bounce = 1'b1;
    limit  = 4'd5;
    drive_cmd(OP_RUN, '0);
    step();
    for (int m = 0; m < 12; m++) begin
      step();
      chk($sformatf("bounce_q%0d", m), ctr, bseq[m]);
    end
    chk("bounce_up_after", up, 1);

    // REVERSE coinciding with q_fb==limit while counting up
    use_model = 1'b0;
    q_force   = 4'd5;
    drive_cmd(OP_REVERSE, '0);
    chk("rev_lim_up", up, 0);
    step();
    chk("rev_lim_hold", up, 0);
    q_force = 4'd0;
    step();
    chk("bounce_at_zero", up, 1);
    drive_cmd(OP_STOP, '0);
    use_model = 1'b1;
    bounce    = 1'b0;
    limit     = '0;
    step();

    // REVERSE in IDLE flips direction and stays stopped
    drive_cmd(OP_REVERSE, '0);
    chk("idle_rev_up", up, 0);
    chk("idle_rev_en", enable, 0);

    // STOP on the edge a div=3 tick is due: the pulse is dropped
    drive_cmd(OP_PRESET, 4'd3);
    step();
    div = 8'd3;
    drive_cmd(OP_RUN, '0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("div3_en_c%0d", i), enable, 0);
    end
    drive_cmd(OP_STOP, '0);
    chk("stop_due_en", enable, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stopped_en_c%0d", i), enable, 0);
    end
    chk("stopped_ctr", ctr, 3);
    chk("stopped_ready", cmd_ready, 1);

    // Lowering div below the running prescaler count ticks on the next edge
    drive_cmd(OP_RUN, '0);
    step();
    chk("live_div_c1", enable, 0);
    step();
    chk("live_div_c2", enable, 0);
    div = 8'd1;
    step();
    chk("live_div_tick", enable, 1);
    drive_cmd(OP_STOP, '0);
    chk("live_div_stop", enable, 0);

    // Reset during PRESET aborts it
    drive_cmd(OP_PRESET, 4'd7);
    chk("pre7_load", load, 1);
    reset = 1'b1;
    step();
    chk("abort_load", load, 0);
    chk("abort_enable", enable, 0);
    chk("abort_up", up, 1);
    chk("abort_load_val", load_val, 0);
    chk("abort_ready", cmd_ready, 0);
    reset = 1'b0;
    step();
    chk("abort_ready_back", cmd_ready, 1);
    chk("abort_idle_en0", enable, 0);
    step();
    chk("abort_idle_en1", enable, 0);
    chk("abort_idle_load", load, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
